// File: rtl/uparc_hazu_pkg.sv
// uparc_hazu_pkg: shared register-number/register widths and types for the hazard unit
package uparc_hazu_pkg;
   localparam int UPARC_REGNO_WIDTH = 5;
   localparam int UPARC_REG_WIDTH = 32;
   localparam int UPARC_NREGS = 1 << UPARC_REGNO_WIDTH;
   typedef logic [UPARC_REGNO_WIDTH-1:0] regno_t;
   typedef logic [UPARC_REG_WIDTH-1:0] reg_t;
endpackage

// File: rtl/uparc_hazu_sel.sv
// uparc_hazu_sel: per-read-port operand select and hazard detect
module uparc_hazu_sel
   import uparc_hazu_pkg::*;
#(
   parameter int NSTAGES = 2
) (
   input  logic [UPARC_REGNO_WIDTH-1:0]         rd_no,
   input  logic [UPARC_REG_WIDTH-1:0]           rd_data,
   input  logic [NSTAGES*UPARC_REGNO_WIDTH-1:0] fwd_no,
   input  logic [NSTAGES*UPARC_REG_WIDTH-1:0]   fwd_data,
   input  logic [NSTAGES-1:0]                   fwd_vld,
   input  logic [UPARC_NREGS-1:0]               pending,
   input  logic                                 cmpl_vld,
   input  logic [UPARC_REGNO_WIDTH-1:0]         cmpl_rd,
   input  logic [UPARC_REG_WIDTH-1:0]           cmpl_data,
   output logic [UPARC_REG_WIDTH-1:0]           data,
   output logic                                 stall
);
   logic cmpl_hit;
   assign cmpl_hit = cmpl_vld && cmpl_rd == rd_no;
   // walk oldest to youngest so the youngest matching stage wins, even if not ready
   always_comb begin
      data = cmpl_hit ? cmpl_data : rd_data;
      stall = pending[rd_no] && !cmpl_hit;
      for (int s = NSTAGES - 1; s >= 0; s--)
         if (fwd_no[s*UPARC_REGNO_WIDTH +: UPARC_REGNO_WIDTH] == rd_no) begin
            data = fwd_data[s*UPARC_REG_WIDTH +: UPARC_REG_WIDTH];
            stall = !fwd_vld[s];
         end
      if (rd_no == '0) begin
         data = rd_data;
         stall = 1'b0;
      end
   end
endmodule

// File: rtl/uparc_hazu.sv
// uparc_hazu: operand forwarding and long-latency write scoreboard hazard unit
// Adds perf_stall_cnt_o (saturating stall-cycle count) when UPARC_HAZU_PERFCNT_EN is defined.
module uparc_hazu
   import uparc_hazu_pkg::*;
#(
   parameter int NREAD = 2,
   parameter int NSTAGES = 2,
   parameter int SB_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 nrst,
   input  logic [NREAD*UPARC_REGNO_WIDTH-1:0]   rd_no_i,
   input  logic [NREAD*UPARC_REG_WIDTH-1:0]     rd_data_i,
   input  logic [NSTAGES*UPARC_REGNO_WIDTH-1:0] fwd_no_i,
   input  logic [NSTAGES*UPARC_REG_WIDTH-1:0]   fwd_data_i,
   input  logic [NSTAGES-1:0]                   fwd_vld_i,
   input  logic                                 issue_vld_i,
   input  logic [UPARC_REGNO_WIDTH-1:0]         issue_rd_i,
   input  logic                                 cmpl_vld_i,
   input  logic [UPARC_REGNO_WIDTH-1:0]         cmpl_rd_i,
   input  logic [UPARC_REG_WIDTH-1:0]           cmpl_data_i,
   input  logic                                 flush_i,
   output logic [NREAD*UPARC_REG_WIDTH-1:0]     fwd_data_o,
   output logic                                 stall_o,
   output logic                                 sb_full_o
`ifdef UPARC_HAZU_PERFCNT_EN
   ,
   output logic [31:0]                          perf_stall_cnt_o
`endif
);
   localparam int CW = $clog2(SB_DEPTH + 1);
   logic [UPARC_NREGS-1:0] pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NREAD-1:0] port_stall;
   logic same, iss, cmp;
   genvar k;
   for (k = 0; k < NREAD; k++) begin : g_sel
      uparc_hazu_sel #(.NSTAGES(NSTAGES)) u_sel (
         .rd_no    (rd_no_i[k*UPARC_REGNO_WIDTH +: UPARC_REGNO_WIDTH]),
         .rd_data  (rd_data_i[k*UPARC_REG_WIDTH +: UPARC_REG_WIDTH]),
         .fwd_no   (fwd_no_i),
         .fwd_data (fwd_data_i),
         .fwd_vld  (fwd_vld_i),
         .pending  (pend_q),
         .cmpl_vld (cmpl_vld_i),
         .cmpl_rd  (cmpl_rd_i),
         .cmpl_data(cmpl_data_i),
         .data     (fwd_data_o[k*UPARC_REG_WIDTH +: UPARC_REG_WIDTH]),
         .stall    (port_stall[k])
      );
   end
   // a completion and re-issue of the same pending register hand the slot straight over
   always_comb begin
      same = issue_vld_i && cmpl_vld_i && issue_rd_i == cmpl_rd_i && pend_q[issue_rd_i];
      iss = issue_vld_i && issue_rd_i != '0 && !pend_q[issue_rd_i] && !sb_full_o;
      cmp = cmpl_vld_i && pend_q[cmpl_rd_i] && !same;
      pend_d = pend_q;
      if (iss)
         pend_d[issue_rd_i] = 1'b1;
      if (cmp)
         pend_d[cmpl_rd_i] = 1'b0;
      cnt_d = cnt_q + CW'(iss) - CW'(cmp);
      if (flush_i) begin
         pend_d = '0;
         cnt_d = '0;
      end
   end
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         pend_q <= '0;
         cnt_q <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q <= cnt_d;
      end
   assign sb_full_o = cnt_q == CW'(SB_DEPTH);
   assign stall_o = |port_stall;
`ifdef UPARC_HAZU_PERFCNT_EN
   logic [31:0] perf_q;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst)
         perf_q <= '0;
      else if (stall_o && !(&perf_q))
         perf_q <= perf_q + 32'd1;
   assign perf_stall_cnt_o = perf_q;
`endif
endmodule

// File: tb/tb_uparc_hazu.sv
// tb_uparc_hazu: table-driven and sequence checks of uparc_hazu with an expected-result queue
module tb_uparc_hazu;
   localparam logic [63:0] RD = {32'h0000F00D, 32'h00000055};
   typedef struct {
      string       name;
      logic [9:0]  rd_no;
      logic [9:0]  fwd_no;
      logic [63:0] fwd_data;
      logic [1:0]  fwd_vld;
      logic        cv;
      logic [4:0]  cr;
      logic [31:0] cd;
      logic [63:0] exp_data;
      logic        exp_stall;
   } vec_t;
   typedef struct {
      string       name;
      logic [63:0] data;
      logic        chk_data;
      logic        stall;
      logic        full;
   } exp_t;
   logic        clk = 1'b0;
   logic        nrst;
   logic [9:0]  rd_no;
   logic [63:0] rd_data;
   logic [9:0]  fwd_no;
   logic [63:0] fwd_data;
   logic [1:0]  fwd_vld;
   logic        issue_vld;
   logic [4:0]  issue_rd;
   logic        cmpl_vld;
   logic [4:0]  cmpl_rd;
   logic [31:0] cmpl_data;
   logic        flush;
   logic [63:0] fwd_data_o;
   logic        stall_o;
   logic        sb_full_o;
`ifdef UPARC_HAZU_PERFCNT_EN
   logic [31:0] perf_stall_cnt_o;
`endif
   int checks = 0;
   int errors = 0;
   exp_t q[$];
   vec_t tbl[10];
   always #5 clk = ~clk;
   uparc_hazu dut (
      .clk        (clk),
      .nrst       (nrst),
      .rd_no_i    (rd_no),
      .rd_data_i  (rd_data),
      .fwd_no_i   (fwd_no),
      .fwd_data_i (fwd_data),
      .fwd_vld_i  (fwd_vld),
      .issue_vld_i(issue_vld),
      .issue_rd_i (issue_rd),
      .cmpl_vld_i (cmpl_vld),
      .cmpl_rd_i  (cmpl_rd),
      .cmpl_data_i(cmpl_data),
      .flush_i    (flush),
      .fwd_data_o (fwd_data_o),
      .stall_o    (stall_o),
      .sb_full_o  (sb_full_o)
`ifdef UPARC_HAZU_PERFCNT_EN
      ,
      .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
   );
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask
   task automatic idle();
      rd_no = '0;
      rd_data = RD;
      fwd_no = '0;
      fwd_data = '0;
      fwd_vld = '0;
      issue_vld = 1'b0;
      issue_rd = '0;
      cmpl_vld = 1'b0;
      cmpl_rd = '0;
      cmpl_data = '0;
      flush = 1'b0;
   endtask
   // inputs are set just after a rising edge; outputs are sampled on the falling edge
   task automatic step(input string nm, input logic [63:0] d, input logic cd, input logic st, input logic fu);
      exp_t e;
      q.push_back('{name: nm, data: d, chk_data: cd, stall: st, full: fu});
      @(negedge clk);
      e = q.pop_front();
      if (e.chk_data)
         chk({e.name, "/data"}, fwd_data_o, e.data);
      chk({e.name, "/stall"}, {63'd0, stall_o}, {63'd0, e.stall});
      chk({e.name, "/full"}, {63'd0, sb_full_o}, {63'd0, e.full});
      @(posedge clk);
      #1;
      idle();
   endtask
   initial begin
      tbl[0] = '{"fwd_young", {5'd6, 5'd5}, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 2'b11, 1'b0, 5'd0, 32'd0, {32'hF00D, 32'hAA}, 1'b0};
      tbl[1] = '{"young_notready", {5'd0, 5'd5}, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 2'b10, 1'b0, 5'd0, 32'd0, 64'd0, 1'b1};
      tbl[2] = '{"fwd_old", {5'd0, 5'd5}, {5'd5, 5'd3}, {32'hBB, 32'hAA}, 2'b11, 1'b0, 5'd0, 32'd0, {32'hF00D, 32'hBB}, 1'b0};
      tbl[3] = '{"old_notready", {5'd0, 5'd5}, {5'd5, 5'd3}, {32'hBB, 32'hAA}, 2'b01, 1'b0, 5'd0, 32'd0, 64'd0, 1'b1};
      tbl[4] = '{"r0_passthru", {5'd0, 5'd0}, {5'd0, 5'd0}, {32'hBB, 32'hAA}, 2'b00, 1'b1, 5'd0, 32'hDEAD, RD, 1'b0};
      tbl[5] = '{"cmpl_bypass", {5'd0, 5'd9}, {5'd3, 5'd4}, {32'hBB, 32'hAA}, 2'b11, 1'b1, 5'd9, 32'h1234, {32'hF00D, 32'h1234}, 1'b0};
      tbl[6] = '{"stage_over_cmpl", {5'd0, 5'd9}, {5'd9, 5'd4}, {32'hBB, 32'hAA}, 2'b11, 1'b1, 5'd9, 32'h1234, {32'hF00D, 32'hBB}, 1'b0};
      tbl[7] = '{"port1_fwd", {5'd4, 5'd2}, {5'd8, 5'd4}, {32'hBB, 32'hAA}, 2'b11, 1'b0, 5'd0, 32'd0, {32'hAA, 32'h55}, 1'b0};
      tbl[8] = '{"port1_stall", {5'd4, 5'd2}, {5'd8, 5'd4}, {32'hBB, 32'hAA}, 2'b10, 1'b0, 5'd0, 32'd0, 64'd0, 1'b1};
      tbl[9] = '{"no_match", {5'd12, 5'd13}, {5'd3, 5'd4}, {32'hBB, 32'hAA}, 2'b11, 1'b1, 5'd14, 32'h77, RD, 1'b0};
      nrst = 1'b0;
      idle();
      step("reset", RD, 1'b1, 1'b0, 1'b0);
      nrst = 1'b1;
      foreach (tbl[i]) begin
         rd_no = tbl[i].rd_no;
         fwd_no = tbl[i].fwd_no;
         fwd_data = tbl[i].fwd_data;
         fwd_vld = tbl[i].fwd_vld;
         cmpl_vld = tbl[i].cv;
         cmpl_rd = tbl[i].cr;
         cmpl_data = tbl[i].cd;
         step(tbl[i].name, tbl[i].exp_data, !tbl[i].exp_stall, tbl[i].exp_stall, 1'b0);
      end
      // issue r7, then it is pending until its completion cycle
      issue_vld = 1'b1; issue_rd = 5'd7; rd_no = 10'd7;
      step("r7_issue", RD, 1'b1, 1'b0, 1'b0);
      rd_no = 10'd7;
      step("r7_pending", 64'd0, 1'b0, 1'b1, 1'b0);
      rd_no = 10'd7; cmpl_vld = 1'b1; cmpl_rd = 5'd7; cmpl_data = 32'h1234;
      step("r7_cmpl", {32'hF00D, 32'h1234}, 1'b1, 1'b0, 1'b0);
      rd_no = 10'd7;
      step("r7_cleared", RD, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         issue_vld = 1'b1; issue_rd = 5'(i);
         step($sformatf("fill_r%0d", i), RD, 1'b1, 1'b0, 1'b0);
      end
      issue_vld = 1'b1; issue_rd = 5'd5;
      step("issue_when_full", RD, 1'b1, 1'b0, 1'b1);
      rd_no = 10'd5;
      step("r5_ignored", RD, 1'b1, 1'b0, 1'b1);
      rd_no = 10'd3;
      step("r3_pending", 64'd0, 1'b0, 1'b1, 1'b1);
      cmpl_vld = 1'b1; cmpl_rd = 5'd1;
      step("cmpl_r1", RD, 1'b1, 1'b0, 1'b1);
      step("not_full", RD, 1'b1, 1'b0, 1'b0);
      issue_vld = 1'b1; issue_rd = 5'd2; cmpl_vld = 1'b1; cmpl_rd = 5'd2; cmpl_data = 32'h22;
      step("same_r2", RD, 1'b1, 1'b0, 1'b0);
      rd_no = 10'd2;
      step("r2_still_pending", 64'd0, 1'b0, 1'b1, 1'b0);
      issue_vld = 1'b1; issue_rd = 5'd1; cmpl_vld = 1'b1; cmpl_rd = 5'd3;
      step("iss_r1_cmpl_r3", RD, 1'b1, 1'b0, 1'b0);
      rd_no = 10'd3;
      step("r3_clear", RD, 1'b1, 1'b0, 1'b0);
      rd_no = 10'd1;
      step("r1_pending", 64'd0, 1'b0, 1'b1, 1'b0);
      issue_vld = 1'b1; issue_rd = 5'd6;
      step("issue_r6", RD, 1'b1, 1'b0, 1'b0);
      cmpl_vld = 1'b1; cmpl_rd = 5'd3;
      step("cmpl_not_pending", RD, 1'b1, 1'b0, 1'b1);
      step("still_full", RD, 1'b1, 1'b0, 1'b1);
      // asynchronous reset while full; stall follows only the stage inputs
      nrst = 1'b0; rd_no = 10'd5; fwd_no = 10'd5; fwd_vld = 2'b00;
      step("in_reset", 64'd0, 1'b0, 1'b1, 1'b0);
      nrst = 1'b1;
      rd_no = 10'd1; cmpl_vld = 1'b1; cmpl_rd = 5'd1; cmpl_data = 32'h99;
      step("stale_cmpl", {32'hF00D, 32'h99}, 1'b1, 1'b0, 1'b0);
      rd_no = 10'd1;
      step("r1_gone", RD, 1'b1, 1'b0, 1'b0);
      for (int i = 10; i <= 12; i++) begin
         issue_vld = 1'b1; issue_rd = 5'(i);
         step($sformatf("pre_flush_r%0d", i), RD, 1'b1, 1'b0, 1'b0);
      end
      flush = 1'b1; issue_vld = 1'b1; issue_rd = 5'd9; cmpl_vld = 1'b1; cmpl_rd = 5'd10; cmpl_data = 32'h10;
      step("flush", RD, 1'b1, 1'b0, 1'b0);
      rd_no = 10'd9;
      step("r9_not_pending", RD, 1'b1, 1'b0, 1'b0);
      rd_no = 10'd11;
      step("r11_flushed", RD, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         issue_vld = 1'b1; issue_rd = 5'(i);
         step($sformatf("refill_r%0d", i), RD, 1'b1, 1'b0, 1'b0);
      end
      step("refull", RD, 1'b1, 1'b0, 1'b1);
`ifdef UPARC_HAZU_PERFCNT_EN
      nrst = 1'b0;
      step("perf_reset", RD, 1'b1, 1'b0, 1'b0);
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rd_no = 10'd5; fwd_no = 10'd5;
         step("perf_stall", 64'd0, 1'b0, 1'b1, 1'b0);
      end
      chk("perf_count", {32'd0, perf_stall_cnt_o}, 64'd3);
      force dut.perf_q = 32'hFFFFFFFE;
      step("perf_preload", RD, 1'b1, 1'b0, 1'b0);
      release dut.perf_q;
      for (int i = 0; i < 3; i++) begin
         rd_no = 10'd5; fwd_no = 10'd5;
         step("perf_sat_stall", 64'd0, 1'b0, 1'b1, 1'b0);
      end
      chk("perf_saturate", {32'd0, perf_stall_cnt_o}, 64'hFFFFFFFF);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
